// File: rtl/ipsxe_floating_point_op_axi4s_tx_v1_0_pkg.sv
// ============================================================================
// Module      : ipsxe_floating_point_op_axi4s_tx_v1_0_pkg
// Description : Shared op-code constants, tdata field layout and fixed-code
//               selection for the floating-point operation AXI4-Stream path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ipsxe_floating_point_op_axi4s_tx_v1_0_pkg;

    localparam int c_tdata_w     = 8;
    localparam int c_code_w      = 3;
    localparam int c_addsub_lsb  = 0;
    localparam int c_cmp_lsb     = 3;
    localparam int c_op_sel_cmp  = 3;

    localparam logic [c_code_w-1:0] c_op_add       = 3'b000;
    localparam logic [c_code_w-1:0] c_op_sub       = 3'b001;
    localparam logic [c_code_w-1:0] c_cmp_code_min = 3'b000;
    localparam logic [c_code_w-1:0] c_cmp_code_max = 3'b111;

    // A nonzero mode parameter pins the code to a constant for the selected operator.
    function automatic logic is_fixed_mode(input int op_sel, input int plus_minus, input int compare);
        if (op_sel == c_op_sel_cmp) begin
            return (compare != 0);
        end
        return (plus_minus != 0);
    endfunction

    function automatic logic [c_code_w-1:0] fixed_code(input int op_sel, input int plus_minus,
                                                       input int compare);
        if (op_sel == c_op_sel_cmp) begin
            if (compare >= 1 && compare <= 8) begin
                return c_code_w'(compare - 1);
            end
            return c_cmp_code_min;
        end
        return (plus_minus == 2) ? c_op_sub : c_op_add;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ipsxe_floating_point_axi4s_skid_v1_0.sv
// ============================================================================
// Module      : ipsxe_floating_point_axi4s_skid_v1_0
// Description : Generic 2-entry skid buffer with registered valid, data and
//               ready; full throughput without a ready combinational path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ipsxe_floating_point_axi4s_skid_v1_0 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_ready;

    logic w_accept;
    logic w_main_free;

    assign w_accept    = i_s_valid & r_ready;
    assign w_main_free = ~r_main_valid | i_m_ready;

    // Ready tracks "skid empty"; when skid is full no accept can happen.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_ready      <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_data <= i_s_data;
                end
            end
            r_ready <= 1'b1;
        end else if (w_accept) begin
            r_skid_data  <= i_s_data;
            r_skid_valid <= 1'b1;
            r_ready      <= 1'b0;
        end
    end

    assign o_s_ready = r_ready;
    assign o_m_valid = r_main_valid;
    assign o_m_data  = r_main_data;

endmodule

`default_nettype wire

// File: rtl/ipsxe_floating_point_op_axi4s_tx_v1_0.sv
// ============================================================================
// Module      : ipsxe_floating_point_op_axi4s_tx_v1_0
// Description : Packs a 3-bit operation code into the AXI4-Stream operation
//               byte and transmits it through a skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ipsxe_floating_point_op_axi4s_tx_v1_0
    import ipsxe_floating_point_op_axi4s_tx_v1_0_pkg::*;
#(
    parameter int OP_SEL        = 0,
    parameter int OP_PLUS_MINUS = 0,
    parameter int OP_COMPARE    = 0
) (
    input  logic        i_aclk,
    input  logic        i_rst,
    input  logic        i_op_valid,
    output logic        o_op_ready,
    input  logic [2:0]  i_op_code,
    input  logic        i_clr_err,
    output logic        o_axi4s_operation_tvalid,
    input  logic        i_axi4s_operation_tready,
    output logic [7:0]  o_axi4s_operation_tdata,
    output logic        o_op_mismatch,
    output logic [15:0] o_tx_count
);

    localparam logic                c_fixed_mode = is_fixed_mode(OP_SEL, OP_PLUS_MINUS, OP_COMPARE);
    localparam logic [c_code_w-1:0] c_fixed      = fixed_code(OP_SEL, OP_PLUS_MINUS, OP_COMPARE);
    localparam int                  c_lsb        = (OP_SEL == c_op_sel_cmp) ? c_cmp_lsb : c_addsub_lsb;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_tvalid;
    logic [c_code_w-1:0]  w_code;
    logic [c_tdata_w-1:0] w_tdata;
    logic [15:0]          r_tx_count;

    assign w_accept = i_op_valid & w_ready;
    assign w_code   = c_fixed_mode ? c_fixed : i_op_code;
    assign w_tdata  = c_tdata_w'(w_code) << c_lsb;

    ipsxe_floating_point_axi4s_skid_v1_0 #(
        .WIDTH (c_tdata_w)
    ) u_skid (
        .i_clk     (i_aclk),
        .i_rst     (i_rst),
        .i_s_valid (i_op_valid),
        .o_s_ready (w_ready),
        .i_s_data  (w_tdata),
        .o_m_valid (w_tvalid),
        .i_m_ready (i_axi4s_operation_tready),
        .o_m_data  (o_axi4s_operation_tdata)
    );

    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            r_tx_count <= 16'h0000;
        end else if (w_tvalid && i_axi4s_operation_tready) begin
            r_tx_count <= r_tx_count + 16'd1;
        end
    end

    generate
        if (c_fixed_mode) begin : g_mismatch
            logic r_mismatch;

            // A new mismatch takes priority over a clear in the same cycle.
            always_ff @(posedge i_aclk) begin
                if (i_rst) begin
                    r_mismatch <= 1'b0;
                end else if (w_accept && (i_op_code != c_fixed)) begin
                    r_mismatch <= 1'b1;
                end else if (i_clr_err) begin
                    r_mismatch <= 1'b0;
                end
            end

            assign o_op_mismatch = r_mismatch;
        end else begin : g_no_mismatch
            logic w_unused_clr;
            assign w_unused_clr  = i_clr_err;
            assign o_op_mismatch = 1'b0;
        end
    endgenerate

    assign o_op_ready               = w_ready;
    assign o_axi4s_operation_tvalid = w_tvalid;
    assign o_tx_count               = r_tx_count;

endmodule

`default_nettype wire

// File: tb/tb_ipsxe_floating_point_op_axi4s_tx_v1_0.sv
// ============================================================================
// Module      : tb_ipsxe_floating_point_op_axi4s_tx_v1_0
// Description : Self-checking bench driving four parameterisations of the
//               operation transmitter from one shared stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ipsxe_floating_point_op_axi4s_tx_v1_0;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code  = 3'd0;
    logic        clr      = 1'b0;
    logic        tready   = 1'b0;

    logic        ready  [4];
    logic        tvalid [4];
    logic        mism   [4];
    logic [7:0]  tdata  [4];
    logic [15:0] cnt    [4];

    int checks = 0;
    int errors = 0;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic [7:0] q3 [$];

    typedef struct {
        logic [2:0] code;
        logic [7:0] exp_addsub;
        logic [7:0] exp_cmp;
    } vec_t;

    vec_t vecs [8];
    logic m2;
    logic m3;

    always #5 clk = ~clk;

    // dut0: add/sub runtime, dut1: compare runtime, dut2: compare fixed 3, dut3: fixed sub
    ipsxe_floating_point_op_axi4s_tx_v1_0 #(.OP_SEL(0), .OP_PLUS_MINUS(0), .OP_COMPARE(0)) u_dut0 (
        .i_aclk(clk), .i_rst(rst), .i_op_valid(op_valid), .o_op_ready(ready[0]),
        .i_op_code(op_code), .i_clr_err(clr), .o_axi4s_operation_tvalid(tvalid[0]),
        .i_axi4s_operation_tready(tready), .o_axi4s_operation_tdata(tdata[0]),
        .o_op_mismatch(mism[0]), .o_tx_count(cnt[0]));
    ipsxe_floating_point_op_axi4s_tx_v1_0 #(.OP_SEL(3), .OP_PLUS_MINUS(0), .OP_COMPARE(0)) u_dut1 (
        .i_aclk(clk), .i_rst(rst), .i_op_valid(op_valid), .o_op_ready(ready[1]),
        .i_op_code(op_code), .i_clr_err(clr), .o_axi4s_operation_tvalid(tvalid[1]),
        .i_axi4s_operation_tready(tready), .o_axi4s_operation_tdata(tdata[1]),
        .o_op_mismatch(mism[1]), .o_tx_count(cnt[1]));
    ipsxe_floating_point_op_axi4s_tx_v1_0 #(.OP_SEL(3), .OP_PLUS_MINUS(0), .OP_COMPARE(4)) u_dut2 (
        .i_aclk(clk), .i_rst(rst), .i_op_valid(op_valid), .o_op_ready(ready[2]),
        .i_op_code(op_code), .i_clr_err(clr), .o_axi4s_operation_tvalid(tvalid[2]),
        .i_axi4s_operation_tready(tready), .o_axi4s_operation_tdata(tdata[2]),
        .o_op_mismatch(mism[2]), .o_tx_count(cnt[2]));
    ipsxe_floating_point_op_axi4s_tx_v1_0 #(.OP_SEL(0), .OP_PLUS_MINUS(2), .OP_COMPARE(0)) u_dut3 (
        .i_aclk(clk), .i_rst(rst), .i_op_valid(op_valid), .o_op_ready(ready[3]),
        .i_op_code(op_code), .i_clr_err(clr), .o_axi4s_operation_tvalid(tvalid[3]),
        .i_axi4s_operation_tready(tready), .o_axi4s_operation_tdata(tdata[3]),
        .o_op_mismatch(mism[3]), .o_tx_count(cnt[3]));

    function automatic logic [7:0] model(input int k, input logic [2:0] c);
        case (k)
            0:       return {5'b00000, c};
            1:       return {2'b00, c, 3'b000};
            2:       return 8'h18;
            default: return 8'h01;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input int k, input logic [7:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            2:       q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    task automatic sb_pop_check(input int k, input logic [7:0] act);
        logic [7:0] e;
        bit         have;
        have = 1'b0;
        e    = 8'h00;
        case (k)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2:       if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL sb_unexpected dut%0d actual=%02h required=none", k, act);
        end else if (act !== e) begin
            errors++;
            $display("FAIL sb_data dut%0d actual=%02h required=%02h", k, act, e);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete(); q1.delete(); q2.delete(); q3.delete();
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (tvalid[k] && tready) sb_pop_check(k, tdata[k]);
                    if (op_valid && ready[k]) sb_push(k, model(k, op_code));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the edge that accepted the code.
    task automatic send(input logic [2:0] c);
        bit acc;
        op_valid = 1'b1;
        op_code  = c;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = ready[0];
            tick();
            if (acc) begin
                op_valid = 1'b0;
                return;
            end
        end
        op_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL send_timeout actual=no_accept required=accept code=%0d", c);
    endtask

    initial begin
        vecs[0] = '{3'd1, 8'h01, 8'h08};
        vecs[1] = '{3'd5, 8'h05, 8'h28};
        vecs[2] = '{3'd6, 8'h06, 8'h30};
        vecs[3] = '{3'd3, 8'h03, 8'h18};
        vecs[4] = '{3'd0, 8'h00, 8'h00};
        vecs[5] = '{3'd7, 8'h07, 8'h38};
        vecs[6] = '{3'd2, 8'h02, 8'h10};
        vecs[7] = '{3'd4, 8'h04, 8'h20};

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_tvalid%0d", k), 32'(tvalid[k]), 32'd0);
            check($sformatf("rst_tdata%0d", k), 32'(tdata[k]), 32'h00);
            check($sformatf("rst_ready%0d", k), 32'(ready[k]), 32'd0);
            check($sformatf("rst_count%0d", k), 32'(cnt[k]), 32'd0);
            check($sformatf("rst_mism%0d", k), 32'(mism[k]), 32'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_rst", 32'(ready[0]), 32'd1);
        tick();

        // Table: one code at a time, latency-1 output for every parameterisation
        tready = 1'b1;
        m2 = 1'b0;
        m3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].code);
            m2 = m2 | (vecs[i].code != 3'd3);
            m3 = m3 | (vecs[i].code != 3'd1);
            @(negedge clk);
            check($sformatf("tbl%0d_tvalid", i), 32'(tvalid[0]), 32'd1);
            check($sformatf("tbl%0d_addsub", i), 32'(tdata[0]), 32'(vecs[i].exp_addsub));
            check($sformatf("tbl%0d_cmp", i), 32'(tdata[1]), 32'(vecs[i].exp_cmp));
            check($sformatf("tbl%0d_cmpfix", i), 32'(tdata[2]), 32'h18);
            check($sformatf("tbl%0d_subfix", i), 32'(tdata[3]), 32'h01);
            check($sformatf("tbl%0d_mism2", i), 32'(mism[2]), 32'(m2));
            check($sformatf("tbl%0d_mism3", i), 32'(mism[3]), 32'(m3));
            tick();
        end
        tick();
        @(negedge clk);
        check("count_after_table", 32'(cnt[0]), 32'd8);
        tick();

        // Back-to-back 1,0,1: consecutive outputs, no bubble
        op_valid = 1'b1;
        op_code  = 3'd1;
        tick();
        op_code = 3'd0;
        @(negedge clk);
        check("b2b_first_valid", 32'(tvalid[0]), 32'd1);
        check("b2b_first_data", 32'(tdata[0]), 32'h01);
        check("b2b_ready", 32'(ready[0]), 32'd1);
        tick();
        op_code = 3'd1;
        @(negedge clk);
        check("b2b_second_valid", 32'(tvalid[0]), 32'd1);
        check("b2b_second_data", 32'(tdata[0]), 32'h00);
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        check("b2b_third_valid", 32'(tvalid[0]), 32'd1);
        check("b2b_third_data", 32'(tdata[0]), 32'h01);
        tick();
        send(3'd6);
        send(3'd3);
        repeat (3) tick();
        @(negedge clk);
        check("count_after_b2b", 32'(cnt[0]), 32'd13);
        check("idle_tvalid", 32'(tvalid[0]), 32'd0);

        // Backpressure: skid fills, ready falls, order preserved on release
        tick();
        tready = 1'b0;
        send(3'd2);
        send(3'd3);
        @(negedge clk);
        check("bp_tvalid", 32'(tvalid[0]), 32'd1);
        check("bp_data", 32'(tdata[0]), 32'h02);
        check("bp_ready_low", 32'(ready[0]), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        check("bp_hold_data", 32'(tdata[0]), 32'h02);
        check("bp_hold_valid", 32'(tvalid[0]), 32'd1);
        check("bp_hold_ready", 32'(ready[0]), 32'd0);
        tick();
        tready = 1'b1;
        @(negedge clk);
        check("bp_rel_data0", 32'(tdata[0]), 32'h02);
        tick();
        @(negedge clk);
        check("bp_rel_data1", 32'(tdata[0]), 32'h03);
        check("bp_rel_valid1", 32'(tvalid[0]), 32'd1);
        check("bp_rel_ready", 32'(ready[0]), 32'd1);
        tick();
        @(negedge clk);
        check("bp_drained", 32'(tvalid[0]), 32'd0);
        check("count_after_bp", 32'(cnt[0]), 32'd15);
        tick();

        // Mismatch flag on the fixed-code instances
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("mm_cleared2", 32'(mism[2]), 32'd0);
        check("mm_cleared3", 32'(mism[3]), 32'd0);
        tick();
        send(3'd0);
        @(negedge clk);
        check("mm_set2", 32'(mism[2]), 32'd1);
        check("mm_set3", 32'(mism[3]), 32'd1);
        check("mm_fix_data", 32'(tdata[2]), 32'h18);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("mm_clr2", 32'(mism[2]), 32'd0);
        tick();
        send(3'd3);
        @(negedge clk);
        check("mm_match2", 32'(mism[2]), 32'd0);
        check("mm_nomatch3", 32'(mism[3]), 32'd1);
        check("mm_runtime0", 32'(mism[0]), 32'd0);
        check("mm_runtime1", 32'(mism[1]), 32'd0);
        tick();
        clr = 1'b1;
        send(3'd5);
        clr = 1'b0;
        @(negedge clk);
        check("mm_set_wins", 32'(mism[2]), 32'd1);
        tick();

        // Reset with both entries buffered
        repeat (3) tick();
        tready = 1'b0;
        send(3'd2);
        send(3'd3);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mid_rst_tvalid", 32'(tvalid[0]), 32'd0);
        check("mid_rst_tdata", 32'(tdata[0]), 32'h00);
        check("mid_rst_count", 32'(cnt[0]), 32'd0);
        check("mid_rst_mism", 32'(mism[2]), 32'd0);
        tick();
        rst    = 1'b0;
        tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_ready", 32'(ready[0]), 32'd1);
        repeat (4) tick();
        @(negedge clk);
        check("mid_rst_no_stale", 32'(tvalid[0]), 32'd0);
        check("mid_rst_count_idle", 32'(cnt[0]), 32'd0);
        tick();

        // Counter wrap
        op_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            op_code = 3'($urandom_range(0, 7));
            tick();
        end
        op_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("count_ffff0", 32'(cnt[0]), 32'h0000FFFF);
        check("count_ffff2", 32'(cnt[2]), 32'h0000FFFF);
        tick();
        send(3'd5);
        repeat (3) tick();
        @(negedge clk);
        check("count_wrap0", 32'(cnt[0]), 32'h00000000);
        check("count_wrap1", 32'(cnt[1]), 32'h00000000);
        check("sb_empty0", 32'(q0.size()), 32'd0);
        check("sb_empty1", 32'(q1.size()), 32'd0);
        check("sb_empty2", 32'(q2.size()), 32'd0);
        check("sb_empty3", 32'(q3.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ipsxe_floating_point_op_axi4s_tx_v1_0.md
Name: ipsxe_floating_point_op_axi4s_tx_v1_0

Overview:
Transmit end of the floating-point operation channel. It accepts a 3-bit operation code from upstream control logic on a valid/ready handshake. It packs the code into the 8-bit AXI4-Stream operation tdata byte, at the bit position and with the fixed-code substitution set by OP_SEL, OP_PLUS_MINUS and OP_COMPARE. It then drives that byte as an AXI4-Stream master through a 2-entry skid buffer, giving full throughput with registered outputs.

Parameters:
OP_SEL, 0, operator select; 3 = compare (code packed in tdata[5:3]), any other value = add/sub (code packed in tdata[2:0])
OP_PLUS_MINUS, 0, add/sub mode; 0 = runtime code, 1 = fixed add (3'b000), 2 = fixed sub (3'b001)
OP_COMPARE, 0, compare mode; 0 = runtime code, 1..8 = fixed code (OP_COMPARE-1)

Ports:
i_aclk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_op_valid  in  1  upstream code valid
o_op_ready  out  1  upstream code accepted when high with i_op_valid
i_op_code  in  3  upstream operation code
i_clr_err  in  1  clears o_op_mismatch
o_axi4s_operation_tvalid  out  1  AXI4-Stream master valid
i_axi4s_operation_tready  in  1  AXI4-Stream slave ready
o_axi4s_operation_tdata  out  8  packed operation byte
o_op_mismatch  out  1  sticky: an accepted runtime code differed from the fixed code
o_tx_count  out  16  count of completed AXI transfers, wraps

Behaviour:
- Reset (i_rst high at a clock edge): tvalid=0, tdata=8'h00, o_op_ready=0 while i_rst is high, o_op_mismatch=0, o_tx_count=0, both buffer entries empty. o_op_ready goes to 1 the first cycle after reset is released.
- Reset mid-transfer discards all buffered codes; no partial transfer completes.
- Effective code:
  - Runtime mode (OP_SEL!=3 with OP_PLUS_MINUS==0, or OP_SEL==3 with OP_COMPARE==0): i_op_code.
  - Fixed mode: the fixed constant; i_op_code is ignored for data.
- Packing:
  - OP_SEL!=3: tdata = {5'b0, code}.
  - OP_SEL==3: tdata = {2'b0, code, 3'b0}.
  - Unused bits are always 0.
- Upstream accept = i_op_valid & o_op_ready.
- o_op_ready is a registered signal equal to "skid entry empty". It never depends combinationally on tready.
- Buffer:
  - main register drives the AXI outputs; skid register holds one extra entry.
  - Accept with main empty, or main draining this cycle: the code loads into main. tvalid=1 the next cycle (latency 1).
  - Accept while main holds and tready=0: the code loads into skid; o_op_ready falls the next cycle.
  - Main drains (tvalid & tready) while skid is full: skid moves to main, skid empties, o_op_ready rises the next cycle.
  - Simultaneous accept and drain with skid empty: the new code goes to main; no bubble.
- AXI rules:
  - tdata is stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - Codes leave in acceptance order.
- o_tx_count increments by 1 on each tvalid & tready; it wraps 16'hFFFF -> 16'h0000.
- Mismatch:
  - In fixed mode, an accept with i_op_code != fixed code sets o_op_mismatch the next cycle. The flag is sticky.
  - i_clr_err clears the flag. If i_clr_err and a new mismatch occur in the same cycle, the set wins.
  - In runtime mode the flag is constant 0.

Decomposition:
- Shared package: op-code constants (ADD=3'b000, SUB=3'b001, compare codes 3'b000..3'b111), tdata field offsets (ADDSUB_LSB=0, CMP_LSB=3), TDATA_W=8, and the fixed-code function mapping OP_PLUS_MINUS / OP_COMPARE to a code.
- One natural sub-module: ipsxe_floating_point_axi4s_skid_v1_0, a generic width-parameterised 2-entry skid buffer. The top level holds the encoding, mismatch and count logic.

Test Plan:
1. OP_SEL=0, OP_PLUS_MINUS=0, tready=1, send codes 1,0,1 back-to-back -> tdata 8'h01, 8'h00, 8'h01 on consecutive cycles starting 1 cycle after the first accept; o_tx_count=3.
2. OP_SEL=3, OP_COMPARE=0, send 3'b101 -> tdata=8'h28.
3. OP_SEL=3, OP_COMPARE=0, send codes 3'b110 and 3'b011 back-to-back -> tdata=8'h30 then 8'h18.
4. tready held 0, send codes 2 then 3 -> tvalid=1 with tdata=8'h02 held stable; o_op_ready=0 after the 2nd accept. Release tready -> 8'h02 then 8'h03, then o_op_ready=1.
5. OP_SEL=3, OP_COMPARE=4, send i_op_code=3'b000 -> tdata=8'h18, o_op_mismatch=1. Pulse i_clr_err -> 0. Send 3'b011 -> flag stays 0.
6. Assert i_rst with 2 entries buffered and tready=0 -> next cycle tvalid=0, tdata=8'h00, o_tx_count=0. No stale code appears after release. o_op_ready=1 one cycle after release.
7. Preload o_tx_count to 16'hFFFF via 65535 transfers, then one more -> count reads 16'h0000.
